// File: rtl/wb_stage.sv
// Writeback stage: commits ALU results and load data to the register file.
// rf_widx/rf_wdata hold the last committed pair so forwarding needs no enable.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   EX/MEM handshake (ready while IDLE)
//   in_result, in_dst   ALU result and destination index
//   in_wr_en            instruction writes a register
//   in_is_load          result arrives later on the memory response
//   flush               squash in-flight and offered instruction
//   mem_rsp_valid/data  load response
//   rf_we/widx/wdata    register-file write port (idx/data hold between commits)
//   busy                waiting for load data
//   timeout_err         sticky load-timeout flag
//   commit_cnt          number of rf_we pulses, wraps
module wb_stage #(
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [IDX_W-1:0]  in_dst,
    input  logic              in_wr_en,
    input  logic              in_is_load,
    input  logic              flush,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              rf_we,
    output logic [IDX_W-1:0]  rf_widx,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic              timeout_err,
    output logic [15:0]       commit_cnt
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_MEM = 1'b1;

    localparam logic [7:0] TIMER_LAST = 8'(MEM_TIMEOUT - 1);

    logic [0:0]       state;
    logic [7:0]       timer;
    logic [IDX_W-1:0] loadDst;
    logic             loadWrEn;
    logic             accept;
    logic             timerExpired;

    assign in_ready     = (state == IDLE);
    assign busy         = (state == WAIT_MEM);
    assign accept       = in_valid & in_ready & ~flush;
    assign timerExpired = (timer == TIMER_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            loadDst     <= '0;
            loadWrEn    <= 1'b0;
            rf_we       <= 1'b0;
            rf_widx     <= '0;
            rf_wdata    <= '0;
            timeout_err <= 1'b0;
            commit_cnt  <= '0;
        end else begin
            // Strobe defaults low; only a commit raises it for one cycle.
            rf_we <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_is_load) begin
                            loadDst  <= in_dst;
                            loadWrEn <= in_wr_en;
                            timer    <= '0;
                            state    <= WAIT_MEM;
                        end else if (in_wr_en) begin
                            rf_we      <= 1'b1;
                            rf_widx    <= in_dst;
                            rf_wdata   <= in_result;
                            commit_cnt <= commit_cnt + 16'd1;
                        end
                    end
                end

                WAIT_MEM: begin
                    timer <= timer + 8'd1;
                    // Priority: flush, then response, then timeout.
                    if (flush) begin
                        state <= IDLE;
                    end else if (mem_rsp_valid) begin
                        state <= IDLE;
                        if (loadWrEn) begin
                            rf_we      <= 1'b1;
                            rf_widx    <= loadDst;
                            rf_wdata   <= mem_rsp_data;
                            commit_cnt <= commit_cnt + 16'd1;
                        end
                    end else if (timerExpired) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [3:0]  in_dst;
    logic        in_wr_en;
    logic        in_is_load;
    logic        flush;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        rf_we;
    logic [3:0]  rf_widx;
    logic [31:0] rf_wdata;
    logic        busy;
    logic        timeout_err;
    logic [15:0] commit_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_stage #(
        .DATA_W(32),
        .IDX_W(4),
        .MEM_TIMEOUT(15)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_result(in_result),
        .in_dst(in_dst),
        .in_wr_en(in_wr_en),
        .in_is_load(in_is_load),
        .flush(flush),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data),
        .rf_we(rf_we),
        .rf_widx(rf_widx),
        .rf_wdata(rf_wdata),
        .busy(busy),
        .timeout_err(timeout_err),
        .commit_cnt(commit_cnt)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic offer(input logic [3:0] dst,
                         input logic [31:0] res,
                         input logic wr,
                         input logic ld);
        in_valid   = 1'b1;
        in_dst     = dst;
        in_result  = res;
        in_wr_en   = wr;
        in_is_load = ld;
    endtask

    task automatic idleIn();
        in_valid   = 1'b0;
        in_is_load = 1'b0;
        in_wr_en   = 1'b0;
    endtask

    task automatic checkResetVals(input string tag);
        check({tag, "_we"}, 32'(rf_we), 32'd0);
        check({tag, "_widx"}, 32'(rf_widx), 32'd0);
        check({tag, "_wdata"}, rf_wdata, 32'd0);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_terr"}, 32'(timeout_err), 32'd0);
        check({tag, "_cnt"}, 32'(commit_cnt), 32'd0);
    endtask

    initial begin
        int n;
        bit sawWe;

        reset         = 1'b1;
        in_valid      = 1'b0;
        in_result     = '0;
        in_dst        = '0;
        in_wr_en      = 1'b0;
        in_is_load    = 1'b0;
        flush         = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        repeat (2) @(negedge clk);
        checkResetVals("rst");
        reset = 1'b0;

        // 1: single ALU write
        offer(4'd3, 32'hDEADBEEF, 1'b1, 1'b0);
        @(negedge clk);
        idleIn();
        check("alu_we", 32'(rf_we), 32'd1);
        check("alu_widx", 32'(rf_widx), 32'd3);
        check("alu_wdata", rf_wdata, 32'hDEADBEEF);
        check("alu_cnt", 32'(commit_cnt), 32'd1);
        @(negedge clk);
        check("alu_we_low", 32'(rf_we), 32'd0);
        check("alu_widx_hold", 32'(rf_widx), 32'd3);
        check("alu_wdata_hold", rf_wdata, 32'hDEADBEEF);

        // 2: back-to-back ALU writes
        offer(4'd1, 32'h0000_0011, 1'b1, 1'b0);
        @(negedge clk);
        check("b2b1_we", 32'(rf_we), 32'd1);
        check("b2b1_widx", 32'(rf_widx), 32'd1);
        check("b2b1_ready", 32'(in_ready), 32'd1);
        offer(4'd2, 32'h0000_0022, 1'b1, 1'b0);
        @(negedge clk);
        idleIn();
        check("b2b2_we", 32'(rf_we), 32'd1);
        check("b2b2_widx", 32'(rf_widx), 32'd2);
        check("b2b2_wdata", rf_wdata, 32'h0000_0022);
        check("b2b2_cnt", 32'(commit_cnt), 32'd3);
        @(negedge clk);
        check("b2b_we_low", 32'(rf_we), 32'd0);

        // 2b: non-writing instruction, no strobe
        offer(4'd6, 32'h0000_0066, 1'b0, 1'b0);
        @(negedge clk);
        idleIn();
        check("nowr_we", 32'(rf_we), 32'd0);
        check("nowr_widx", 32'(rf_widx), 32'd2);
        check("nowr_cnt", 32'(commit_cnt), 32'd3);

        // 3: load with response after 4 busy cycles
        offer(4'd5, 32'hFFFF_FFFF, 1'b1, 1'b1);
        @(negedge clk);
        idleIn();
        for (int i = 0; i < 4; i++) begin
            check("ld_busy", 32'(busy), 32'd1);
            check("ld_ready", 32'(in_ready), 32'd0);
            check("ld_we_low", 32'(rf_we), 32'd0);
            if (i == 3) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 32'h12345678;
            end
            @(negedge clk);
        end
        mem_rsp_valid = 1'b0;
        check("ld_we", 32'(rf_we), 32'd1);
        check("ld_widx", 32'(rf_widx), 32'd5);
        check("ld_wdata", rf_wdata, 32'h12345678);
        check("ld_idle", 32'(busy), 32'd0);
        check("ld_cnt", 32'(commit_cnt), 32'd4);

        // 4: load timeout after 15 busy cycles
        offer(4'd7, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        idleIn();
        n     = 0;
        sawWe = 1'b0;
        while (busy && n < 40) begin
            n++;
            if (rf_we) sawWe = 1'b1;
            @(negedge clk);
        end
        check("to_cycles", 32'(n), 32'd15);
        check("to_no_we", 32'(sawWe | rf_we), 32'd0);
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_ready", 32'(in_ready), 32'd1);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0BAD;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("stray_we", 32'(rf_we), 32'd0);
        check("stray_wdata", rf_wdata, 32'h12345678);
        check("stray_busy", 32'(busy), 32'd0);
        check("stray_cnt", 32'(commit_cnt), 32'd4);

        // 5: flush beats a same-cycle response
        offer(4'd9, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        idleIn();
        flush         = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_CAFE;
        @(negedge clk);
        flush         = 1'b0;
        mem_rsp_valid = 1'b0;
        check("fl_we", 32'(rf_we), 32'd0);
        check("fl_busy", 32'(busy), 32'd0);
        check("fl_ready", 32'(in_ready), 32'd1);
        check("fl_widx", 32'(rf_widx), 32'd5);
        check("fl_wdata", rf_wdata, 32'h12345678);

        // 5b: flush in IDLE blocks the offered instruction
        offer(4'd10, 32'hAAAA_AAAA, 1'b1, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        idleIn();
        flush = 1'b0;
        check("fli_we", 32'(rf_we), 32'd0);
        check("fli_widx", 32'(rf_widx), 32'd5);
        check("fli_cnt", 32'(commit_cnt), 32'd4);

        // 6: reset during WAIT_MEM
        offer(4'd4, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        idleIn();
        check("rw_busy", 32'(busy), 32'd1);
        reset         = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_5555;
        @(negedge clk);
        reset         = 1'b0;
        mem_rsp_valid = 1'b0;
        checkResetVals("rw");

        // 6b: commit counter wrap
        force dut.commit_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.commit_cnt;
        check("wrap_pre", 32'(commit_cnt), 32'h0000_FFFF);
        offer(4'd2, 32'h0000_0055, 1'b1, 1'b0);
        @(negedge clk);
        idleIn();
        check("wrap_we", 32'(rf_we), 32'd1);
        check("wrap_cnt", 32'(commit_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
